// File: rtl/sched_pkg.sv
// Shared types and helpers for the shared-resource scheduler.
//   sched_state_t : scheduler FSM encoding exposed on the state port
//   PRIO_IDX      : requester index that may preempt any other owner
//   MAX_N         : largest supported requester count
//   onehot()      : index to one-hot vector, MAX_N bits wide
package sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FIRST = 2'd1,
        HOLD  = 2'd2
    } sched_state_t;

    localparam int unsigned PRIO_IDX = 0;
    localparam int unsigned MAX_N    = 8;

    // Callers truncate the result to their own requester count.
    function automatic logic [MAX_N-1:0] onehot(input int unsigned idx);
        return MAX_N'(1) << idx;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational arbiter for the scheduler.
//   req    : level requests
//   mask   : requesters eligible for this pick
//   rr_ptr : last round-robin winner (always in 1..N-1)
//   winner : chosen index, 0 when nothing is eligible
//   valid  : at least one eligible request
// The priority requester wins outright when eligible. Otherwise the search
// runs over 1..N-1 starting just after rr_ptr and wrapping past index 0.
module rr_pick #(
    parameter int unsigned N  = 3,
    parameter int unsigned IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [N-1:0]  mask,
    input  logic [IW-1:0] rr_ptr,
    output logic [IW-1:0] winner,
    output logic          valid
);
    import sched_pkg::*;

    logic [N-1:0] cand;
    int unsigned  idx;

    always_comb begin
        cand   = req & mask;
        winner = '0;
        valid  = 1'b0;
        idx    = 0;
        if (cand[PRIO_IDX]) begin
            winner = IW'(PRIO_IDX);
            valid  = 1'b1;
        end else begin
            // Map offset k onto the ring 1..N-1 that follows rr_ptr.
            for (int unsigned k = 0; k < N - 1; k++) begin
                idx = ((32'(rr_ptr) + k) % (N - 1)) + 1;
                if (!valid && cand[IW'(idx)]) begin
                    winner = IW'(idx);
                    valid  = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/shared_resource_scheduler.sv
// Grants a single shared resource to one of N requesters.
// Requester 0 may preempt any other owner; requesters 1..N-1 rotate
// round-robin. An optional hold limit forces a release from an owner that
// never signals done.
//   clk, reset  : clock, synchronous active-low reset
//   req, done   : per-requester request level and release strobe
//   gnt, owner  : one-hot grant and owner index (0 when idle)
//   state, busy : FSM state (IDLE/FIRST/HOLD) and state != IDLE
//   nb_preempt  : saturating count of preemptions by requester 0
//   nb_timeout  : saturating count of forced releases
module shared_resource_scheduler #(
    parameter int unsigned N        = 3,
    parameter int unsigned MAX_HOLD = 16,
    parameter int unsigned CNT_W    = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N-1:0]         req,
    input  logic [N-1:0]         done,
    output logic [N-1:0]         gnt,
    output logic [$clog2(N)-1:0] owner,
    output logic [1:0]           state,
    output logic                 busy,
    output logic [CNT_W-1:0]     nb_preempt,
    output logic [CNT_W-1:0]     nb_timeout
);
    import sched_pkg::*;

    localparam int unsigned IW = $clog2(N);
    localparam int unsigned HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD + 1) : 1;

    sched_state_t  state_q;
    logic [IW-1:0] rr_ptr;
    logic [HW-1:0] hold_cnt;

    logic [IW-1:0] win_all_c, win_ex_c;
    logic          valid_all_c, valid_ex_c;
    logic          done_own_c, preempt_c, at_limit_c;

    // Normal arbitration over every requester.
    rr_pick #(.N(N), .IW(IW)) u_pick_all (
        .req    (req),
        .mask   ({N{1'b1}}),
        .rr_ptr (rr_ptr),
        .winner (win_all_c),
        .valid  (valid_all_c)
    );

    // Arbitration after a forced release: the current owner is excluded.
    rr_pick #(.N(N), .IW(IW)) u_pick_ex (
        .req    (req),
        .mask   (~gnt),
        .rr_ptr (rr_ptr),
        .winner (win_ex_c),
        .valid  (valid_ex_c)
    );

    // gnt is onehot(owner) while busy, so masking done with gnt isolates done[owner].
    assign done_own_c = |(done & gnt);
    assign preempt_c  = (owner != IW'(PRIO_IDX)) && req[PRIO_IDX];
    assign at_limit_c = (MAX_HOLD != 0) && (hold_cnt == HW'(MAX_HOLD));

    assign state = 2'(state_q);

    // Scheduler FSM with registered grant, owner and counters.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= IDLE;
            gnt        <= '0;
            owner      <= '0;
            busy       <= 1'b0;
            rr_ptr     <= IW'(N - 1);
            hold_cnt   <= '0;
            nb_preempt <= '0;
            nb_timeout <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (|req) begin
                        state_q <= FIRST;
                        busy    <= 1'b1;
                        owner   <= win_all_c;
                        gnt     <= N'(onehot(32'(win_all_c)));
                        if (win_all_c != IW'(PRIO_IDX)) rr_ptr <= win_all_c;
                    end
                end

                FIRST: begin
                    // done is not honoured in FIRST, so preemption needs no done check.
                    if (preempt_c) begin
                        state_q <= FIRST;
                        owner   <= IW'(PRIO_IDX);
                        gnt     <= N'(onehot(PRIO_IDX));
                        if (nb_preempt != '1) nb_preempt <= nb_preempt + 1'b1;
                    end else begin
                        state_q  <= HOLD;
                        hold_cnt <= HW'(1);
                    end
                end

                HOLD: begin
                    if (done_own_c) begin
                        if (valid_all_c) begin
                            state_q <= FIRST;
                            owner   <= win_all_c;
                            gnt     <= N'(onehot(32'(win_all_c)));
                            if (win_all_c != IW'(PRIO_IDX)) rr_ptr <= win_all_c;
                        end else begin
                            state_q <= IDLE;
                            busy    <= 1'b0;
                            owner   <= '0;
                            gnt     <= '0;
                        end
                    end else if (preempt_c) begin
                        state_q <= FIRST;
                        owner   <= IW'(PRIO_IDX);
                        gnt     <= N'(onehot(PRIO_IDX));
                        if (nb_preempt != '1) nb_preempt <= nb_preempt + 1'b1;
                    end else if (at_limit_c) begin
                        if (nb_timeout != '1) nb_timeout <= nb_timeout + 1'b1;
                        if (valid_ex_c) begin
                            state_q <= FIRST;
                            owner   <= win_ex_c;
                            gnt     <= N'(onehot(32'(win_ex_c)));
                            if (win_ex_c != IW'(PRIO_IDX)) rr_ptr <= win_ex_c;
                        end else begin
                            state_q <= IDLE;
                            busy    <= 1'b0;
                            owner   <= '0;
                            gnt     <= '0;
                        end
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end

                default: begin
                    state_q <= IDLE;
                    busy    <= 1'b0;
                    owner   <= '0;
                    gnt     <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shared_resource_scheduler.sv
// Self-checking bench for shared_resource_scheduler (N=3, MAX_HOLD=4, CNT_W=8).
// A behavioural model predicts every registered output; predictions are
// queued as stimulus is applied and compared after the following clock edge.
module tb_shared_resource_scheduler;

    localparam int unsigned N        = 3;
    localparam int unsigned MAX_HOLD = 4;
    localparam int unsigned CNT_W    = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] req;
    logic [2:0] done;
    logic [2:0] gnt;
    logic [1:0] owner;
    logic [1:0] state;
    logic       busy;
    logic [7:0] nb_preempt;
    logic [7:0] nb_timeout;

    always #5 clk = ~clk;

    shared_resource_scheduler #(
        .N        (N),
        .MAX_HOLD (MAX_HOLD),
        .CNT_W    (CNT_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .done       (done),
        .gnt        (gnt),
        .owner      (owner),
        .state      (state),
        .busy       (busy),
        .nb_preempt (nb_preempt),
        .nb_timeout (nb_timeout)
    );

    typedef struct packed {
        logic [2:0] gnt;
        logic [1:0] owner;
        logic [1:0] state;
        logic       busy;
        logic [7:0] np;
        logic [7:0] nt;
    } obs_t;

    obs_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;

    // Reference model state: 0=IDLE, 1=FIRST, 2=HOLD.
    int m_state, m_owner, m_rr, m_hold, m_np, m_nt;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int m_arb(input logic [2:0] r, input logic [2:0] mask);
        logic [2:0] c;
        int         p;
        c = r & mask;
        if (c[0]) return 0;
        p = m_rr;
        for (int i = 0; i < int'(N); i++) begin
            p = (p + 1) % int'(N);
            if (p != 0 && c[2'(p)]) return p;
        end
        return -1;
    endfunction

    task automatic m_grant(input int p);
        m_state = 1;
        m_owner = p;
        if (p != 0) m_rr = p;
    endtask

    task automatic m_idle();
        m_state = 0;
        m_owner = 0;
    endtask

    task automatic m_preempt();
        m_state = 1;
        m_owner = 0;
        if (m_np < 255) m_np++;
    endtask

    task automatic model_step(input logic rst, input logic [2:0] r, input logic [2:0] d);
        int p;
        if (!rst) begin
            m_state = 0; m_owner = 0; m_rr = int'(N) - 1;
            m_hold  = 0; m_np    = 0; m_nt = 0;
        end else begin
            case (m_state)
                0: if (r != 3'b000) m_grant(m_arb(r, 3'b111));
                1: begin
                    if (m_owner != 0 && r[0]) m_preempt();
                    else begin m_state = 2; m_hold = 1; end
                end
                default: begin
                    if (d[2'(m_owner)]) begin
                        if (r != 3'b000) m_grant(m_arb(r, 3'b111));
                        else m_idle();
                    end else if (m_owner != 0 && r[0]) begin
                        m_preempt();
                    end else if (MAX_HOLD != 0 && m_hold == int'(MAX_HOLD)) begin
                        if (m_nt < 255) m_nt++;
                        p = m_arb(r, ~(3'b001 << m_owner));
                        if (p < 0) m_idle();
                        else m_grant(p);
                    end else begin
                        m_hold++;
                    end
                end
            endcase
        end
    endtask

    // Apply one cycle of stimulus, predict, then compare after the edge.
    task automatic step(input logic rst, input logic [2:0] r, input logic [2:0] d);
        obs_t e;
        obs_t o;
        reset = rst;
        req   = r;
        done  = d;
        model_step(rst, r, d);
        e.gnt   = (m_state != 0) ? 3'(3'b001 << m_owner) : 3'b000;
        e.owner = 2'(m_owner);
        e.state = 2'(m_state);
        e.busy  = (m_state != 0);
        e.np    = 8'(m_np);
        e.nt    = 8'(m_nt);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        cyc++;
        o = '{gnt: gnt, owner: owner, state: state, busy: busy, np: nb_preempt, nt: nb_timeout};
        e = exp_q.pop_front();
        check_eq("sb_gnt",   32'(o.gnt),   32'(e.gnt));
        check_eq("sb_owner", 32'(o.owner), 32'(e.owner));
        check_eq("sb_state", 32'(o.state), 32'(e.state));
        check_eq("sb_busy",  32'(o.busy),  32'(e.busy));
        check_eq("sb_np",    32'(o.np),    32'(e.np));
        check_eq("sb_nt",    32'(o.nt),    32'(e.nt));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [2:0] exp_seq [2];
        exp_seq[0] = 3'b100;
        exp_seq[1] = 3'b010;
        reset = 1'b0;
        req   = 3'b000;
        done  = 3'b000;

        // Reset with all requests high, then release with no requests.
        step(1'b0, 3'b111, 3'b000);
        check_eq("rst_gnt",   32'(gnt),        32'(3'b000));
        check_eq("rst_state", 32'(state),      32'(0));
        check_eq("rst_np",    32'(nb_preempt), 32'(0));
        check_eq("rst_nt",    32'(nb_timeout), 32'(0));
        step(1'b1, 3'b000, 3'b000);
        check_eq("idle_gnt",  32'(gnt),        32'(3'b000));

        // Round-robin between 1 and 2, done on the second HOLD cycle.
        step(1'b1, 3'b110, 3'b000);
        check_eq("rr_gnt0",   32'(gnt),   32'(3'b010));
        check_eq("rr_first0", 32'(state), 32'(1));
        for (int i = 0; i < 2; i++) begin
            step(1'b1, 3'b110, 3'b000);
            step(1'b1, 3'b110, 3'b000);
            step(1'b1, 3'b110, gnt);
            check_eq("rr_gnt",   32'(gnt),   32'(exp_seq[i]));
            check_eq("rr_first", 32'(state), 32'(1));
        end

        // Preemption of owner 2 in HOLD.
        step(1'b0, 3'b000, 3'b000);
        step(1'b1, 3'b100, 3'b000);
        step(1'b1, 3'b100, 3'b000);
        step(1'b1, 3'b101, 3'b000);
        check_eq("pre_gnt",   32'(gnt),        32'(3'b001));
        check_eq("pre_state", 32'(state),      32'(1));
        check_eq("pre_np",    32'(nb_preempt), 32'(1));

        // Same, but done[2] coincides: normal release, not a preemption.
        step(1'b0, 3'b000, 3'b000);
        step(1'b1, 3'b100, 3'b000);
        step(1'b1, 3'b100, 3'b000);
        step(1'b1, 3'b101, 3'b100);
        check_eq("rel_gnt", 32'(gnt),        32'(3'b001));
        check_eq("rel_np",  32'(nb_preempt), 32'(0));

        // Timeout of owner 1 with requester 2 waiting.
        step(1'b0, 3'b000, 3'b000);
        step(1'b1, 3'b110, 3'b000);
        repeat (5) step(1'b1, 3'b110, 3'b000);
        check_eq("to_gnt", 32'(gnt),        32'(3'b100));
        check_eq("to_nt",  32'(nb_timeout), 32'(1));

        // Timeout with only the owner requesting goes idle.
        step(1'b0, 3'b000, 3'b000);
        step(1'b1, 3'b010, 3'b000);
        repeat (5) step(1'b1, 3'b010, 3'b000);
        check_eq("toi_state", 32'(state),      32'(0));
        check_eq("toi_gnt",   32'(gnt),        32'(3'b000));
        check_eq("toi_nt",    32'(nb_timeout), 32'(1));

        // done during FIRST and done from a non-owner are both ignored.
        step(1'b0, 3'b000, 3'b000);
        step(1'b1, 3'b010, 3'b000);
        step(1'b1, 3'b010, 3'b010);
        check_eq("ign_first_gnt",   32'(gnt),   32'(3'b010));
        check_eq("ign_first_state", 32'(state), 32'(2));
        step(1'b1, 3'b010, 3'b100);
        check_eq("ign_other_gnt",   32'(gnt),   32'(3'b010));
        check_eq("ign_other_state", 32'(state), 32'(2));

        // Repeated preemptions saturate the counter.
        step(1'b0, 3'b000, 3'b000);
        step(1'b1, 3'b010, 3'b000);
        for (int i = 0; i < 300; i++) begin
            step(1'b1, 3'b011, 3'b000);
            step(1'b1, 3'b010, 3'b001);
            step(1'b1, 3'b010, 3'b001);
        end
        check_eq("sat_np", 32'(nb_preempt), 32'(255));

        // Reset while owner 1 is in HOLD drops the grant at that edge.
        step(1'b1, 3'b010, 3'b000);
        check_eq("hold_state", 32'(state), 32'(2));
        step(1'b0, 3'b010, 3'b000);
        check_eq("midrst_gnt", 32'(gnt),   32'(3'b000));

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 99) != 0) ? 1'b1 : 1'b0,
                 3'($urandom_range(0, 7)),
                 ($urandom_range(0, 2) == 0) ? 3'($urandom_range(0, 7)) : 3'b000);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
